eth_mac_stats: RTL and testbench

Per-port statistics counter bank for the 1G MAC/FIFO subsystem. Counts the single-cycle status pulses produced by one or more MAC-with-FIFO instances after those pulses are synchronised into the logic clock domain. Exposes every counter through a valid/ready read port with optional clear-on-read. Sits beside the MAC wrappers in the logic clock domain and feeds the host register interface.

---
 rtl/eth_mac_stats_pkg.sv | 21 ++
 rtl/eth_mac_stats_cell.sv | 86 ++++++++
 rtl/eth_mac_stats.sv | 125 ++++++++++++
 tb/tb_eth_mac_stats.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_mac_stats_pkg.sv
// Shared definitions for the per-port MAC statistics counter bank:
// event bit positions within a port's 8-bit event field and the read FSM states.
package eth_mac_stats_pkg;

  localparam int EVENTS_PER_PORT = 8;

  localparam int EV_TX_GOOD      = 0;
  localparam int EV_TX_BAD       = 1;
  localparam int EV_TX_UNDERFLOW = 2;
  localparam int EV_TX_FIFO_OVF  = 3;
  localparam int EV_RX_GOOD      = 4;
  localparam int EV_RX_BAD       = 5;
  localparam int EV_RX_BAD_FCS   = 6;
  localparam int EV_RX_FIFO_OVF  = 7;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/eth_mac_stats_cell.sv
// One statistics counter with its sticky wrap/saturation flag.
// With ETH_MAC_STATS_SNAPSHOT_EN defined, a shadow copy is captured on snap
// and presented on the read outputs; otherwise the live value is presented.
module eth_mac_stats_cell
  import eth_mac_stats_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clr,
  input  logic                   snap,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic                   rd_wrap
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wrap_q, wrap_d;

  // Next live value: a clear wins but still absorbs a same-cycle event, so no event is lost.
  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    if (clr) begin
      count_d = {{(COUNT_WIDTH-1){1'b0}}, inc};
      wrap_d  = 1'b0;
    end else if (inc) begin
      if (&count_q) begin
        wrap_d = 1'b1;
        if (SATURATE == 0) begin
          count_d = '0;
        end
      end else begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  // Live counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef ETH_MAC_STATS_SNAPSHOT_EN
  logic [COUNT_WIDTH-1:0] shadow_count_q, shadow_count_d;
  logic                   shadow_wrap_q, shadow_wrap_d;

  // Snapshot takes the registered live value, so a read in the same cycle still sees the old shadow.
  always_comb begin
    shadow_count_d = shadow_count_q;
    shadow_wrap_d  = shadow_wrap_q;
    if (snap) begin
      shadow_count_d = count_q;
      shadow_wrap_d  = wrap_q;
    end
  end

  // Shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_count_q <= '0;
      shadow_wrap_q  <= 1'b0;
    end else begin
      shadow_count_q <= shadow_count_d;
      shadow_wrap_q  <= shadow_wrap_d;
    end
  end

  assign rd_count = shadow_count_q;
  assign rd_wrap  = shadow_wrap_q;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign rd_count    = count_q;
  assign rd_wrap     = wrap_q;
`endif

endmodule

// File: rtl/eth_mac_stats.sv
// Statistics counter bank for PORTS MAC instances, 8 event counters per port,
// read through a valid/ready request/response port with optional clear-on-read.
// Optional feature macro: ETH_MAC_STATS_SNAPSHOT_EN (shadow snapshot registers).
module eth_mac_stats
  import eth_mac_stats_pkg::*;
#(
  parameter int PORTS       = 1,
  parameter int COUNT_WIDTH = 32,
  parameter int SATURATE    = 1,
  parameter int PORT_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*8-1:0]     stat_event,
  input  logic                   snapshot,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [PORT_WIDTH-1:0]  rd_req_port,
  input  logic [2:0]             rd_req_index,
  input  logic                   rd_req_clear,
  output logic                   rd_resp_valid,
  input  logic                   rd_resp_ready,
  output logic [COUNT_WIDTH-1:0] rd_resp_data,
  output logic                   rd_resp_wrap,
  output logic                   rd_resp_error
);

  localparam int NUM_CELLS = PORTS * EVENTS_PER_PORT;

  logic [COUNT_WIDTH-1:0] cell_count [NUM_CELLS];
  logic [NUM_CELLS-1:0]   cell_wrap;
  logic [NUM_CELLS-1:0]   cell_clr;

  logic                   port_ok;
  int                     sel;
  logic                   accept;
  logic [COUNT_WIDTH-1:0] read_data;
  logic                   read_wrap;

  rd_state_e              state_q, state_d;
  logic [COUNT_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                   resp_wrap_q, resp_wrap_d;
  logic                   resp_error_q, resp_error_d;

  assign port_ok = int'(rd_req_port) < PORTS;
  assign sel     = int'(rd_req_port) * EVENTS_PER_PORT + int'(rd_req_index);

  genvar gi;
  for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
    assign cell_clr[gi] = accept && rd_req_clear && port_ok && (sel == gi);

    eth_mac_stats_cell #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .SATURATE    (SATURATE)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .inc      (stat_event[gi]),
      .clr      (cell_clr[gi]),
      .snap     (snapshot),
      .rd_count (cell_count[gi]),
      .rd_wrap  (cell_wrap[gi])
    );
  end

  // Read mux: out-of-range ports return zero so the response carries only the error flag.
  always_comb begin
    read_data = '0;
    read_wrap = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (port_ok && (sel == i)) begin
        read_data = cell_count[i];
        read_wrap = cell_wrap[i];
      end
    end
  end

  // Read FSM next state: accept in IDLE and latch the response, hold it in RESP until consumed.
  always_comb begin
    state_d      = state_q;
    resp_data_d  = resp_data_q;
    resp_wrap_d  = resp_wrap_q;
    resp_error_d = resp_error_q;
    accept       = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_req_valid) begin
          accept       = 1'b1;
          resp_data_d  = read_data;
          resp_wrap_d  = read_wrap;
          resp_error_d = !port_ok;
          state_d      = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rd_resp_ready) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Read FSM state and response registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      resp_data_q  <= '0;
      resp_wrap_q  <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_data_q  <= resp_data_d;
      resp_wrap_q  <= resp_wrap_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign rd_req_ready  = (state_q == RD_IDLE);
  assign rd_resp_valid = (state_q == RD_RESP);
  assign rd_resp_data  = resp_data_q;
  assign rd_resp_wrap  = resp_wrap_q;
  assign rd_resp_error = resp_error_q;

endmodule

// File: tb/tb_eth_mac_stats.sv
// Self-checking bench for eth_mac_stats: two instances (saturating and wrapping,
// 3 ports, 8-bit counters) share all stimulus; expected responses are queued
// on request and popped when the response appears.
module tb_eth_mac_stats;

  localparam int PORTS = 3;
  localparam int CW    = 8;
  localparam int PW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [PORTS*8-1:0] stat_event;
  logic             snapshot;
  logic             rd_req_valid;
  logic [PW-1:0]    rd_req_port;
  logic [2:0]       rd_req_index;
  logic             rd_req_clear;
  logic             rd_resp_ready;

  logic             s_req_ready, s_resp_valid, s_resp_wrap, s_resp_error;
  logic [CW-1:0]    s_resp_data;
  logic             w_req_ready, w_resp_valid, w_resp_wrap, w_resp_error;
  logic [CW-1:0]    w_resp_data;

  typedef struct {
    string         tag;
    logic [CW-1:0] data_s;
    logic [CW-1:0] data_w;
    logic          wrap_s;
    logic          wrap_w;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  eth_mac_stats #(.PORTS(PORTS), .COUNT_WIDTH(CW), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .stat_event(stat_event), .snapshot(snapshot),
    .rd_req_valid(rd_req_valid), .rd_req_ready(s_req_ready),
    .rd_req_port(rd_req_port), .rd_req_index(rd_req_index), .rd_req_clear(rd_req_clear),
    .rd_resp_valid(s_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(s_resp_data), .rd_resp_wrap(s_resp_wrap), .rd_resp_error(s_resp_error)
  );

  eth_mac_stats #(.PORTS(PORTS), .COUNT_WIDTH(CW), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .stat_event(stat_event), .snapshot(snapshot),
    .rd_req_valid(rd_req_valid), .rd_req_ready(w_req_ready),
    .rd_req_port(rd_req_port), .rd_req_index(rd_req_index), .rd_req_clear(rd_req_clear),
    .rd_resp_valid(w_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(w_resp_data), .rd_resp_wrap(w_resp_wrap), .rd_resp_error(w_resp_error)
  );

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse one event bit for n consecutive cycles.
  task automatic pulse(input int p, input int b, input int n);
    repeat (n) begin
      stat_event = '0;
      stat_event[p*8+b] = 1'b1;
      tick();
    end
    stat_event = '0;
  endtask

  // Snapshot pulse; no effect in the default build, refreshes shadows otherwise.
  task automatic doSnap();
    snapshot = 1'b1;
    tick();
    snapshot = 1'b0;
  endtask

  // Wait (bounded) for the response, pop its expectation, compare, then consume it.
  task automatic checkOutput();
    exp_t e;
    int   n = 0;
    while (!s_resp_valid && n < 20) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    if (!s_resp_valid) begin
      check({e.tag, "/timeout"}, 64'(s_resp_valid), 64'd1);
      return;
    end
    check({e.tag, "/wvalid"}, 64'(w_resp_valid), 64'd1);
    check({e.tag, "/sdata"},  64'(s_resp_data),  64'(e.data_s));
    check({e.tag, "/swrap"},  64'(s_resp_wrap),  64'(e.wrap_s));
    check({e.tag, "/serr"},   64'(s_resp_error), 64'(e.err));
    check({e.tag, "/wdata"},  64'(w_resp_data),  64'(e.data_w));
    check({e.tag, "/wwrap"},  64'(w_resp_wrap),  64'(e.wrap_w));
    check({e.tag, "/werr"},   64'(w_resp_error), 64'(e.err));
    rd_resp_ready = 1'b1;
    tick();
    rd_resp_ready = 1'b0;
    check({e.tag, "/idle_valid"}, 64'(s_resp_valid), 64'd0);
    check({e.tag, "/idle_ready"}, 64'(s_req_ready),  64'd1);
  endtask

  // Issue one read (with optional events in the acceptance cycle) and queue its expectation.
  task automatic applyStimulus(input string tag, input int p, input int idx, input logic clr,
                               input logic [PORTS*8-1:0] ev,
                               input logic [CW-1:0] ds, input logic [CW-1:0] dw,
                               input logic ws, input logic ww, input logic err, input int hold);
    exp_t e;
    check({tag, "/req_ready"}, 64'(s_req_ready), 64'd1);
    rd_req_valid = 1'b1;
    rd_req_port  = PW'(p);
    rd_req_index = 3'(idx);
    rd_req_clear = clr;
    stat_event   = ev;
    e.tag = tag; e.data_s = ds; e.data_w = dw; e.wrap_s = ws; e.wrap_w = ww; e.err = err;
    sb.push_back(e);
    tick();
    rd_req_valid = 1'b0;
    rd_req_clear = 1'b0;
    stat_event   = '0;
    check({tag, "/latency"}, 64'(s_resp_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "/hold_ready"}, 64'(s_req_ready),  64'd0);
      check({tag, "/hold_valid"}, 64'(s_resp_valid), 64'd1);
      check({tag, "/hold_data"},  64'(s_resp_data),  64'(ds));
      check({tag, "/hold_err"},   64'(s_resp_error), 64'(err));
      tick();
    end
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; stat_event = '0; snapshot = 1'b0; rd_req_valid = 1'b0;
    rd_req_port = '0; rd_req_index = '0; rd_req_clear = 1'b0; rd_resp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("reset/req_ready",  64'(s_req_ready),  64'd1);
    check("reset/resp_valid", 64'(s_resp_valid), 64'd0);
    check("reset/resp_data",  64'(s_resp_data),  64'd0);
    check("reset/resp_wrap",  64'(s_resp_wrap),  64'd0);
    check("reset/resp_error", 64'(s_resp_error), 64'd0);

    // Basic count: 5 rx_good pulses on port 0.
    pulse(0, 4, 5);
    doSnap();
    applyStimulus("rd04", 0, 4, 1'b0, '0, 8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 0);

    // 300 pulses: saturating instance sticks at 255, wrapping one lands on 44.
    pulse(0, 2, 300);
    doSnap();
    applyStimulus("rd02_clr", 0, 2, 1'b1, '0, 8'd255, 8'd44, 1'b1, 1'b1, 1'b0, 0);
    doSnap();
    applyStimulus("rd02_after_clr", 0, 2, 1'b0, '0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 0);

    // Clear-read with a same-cycle event: old value returned, event kept.
    pulse(0, 6, 7);
    doSnap();
    applyStimulus("rd06_clr_ev", 0, 6, 1'b1, 24'h000040, 8'd7, 8'd7, 1'b0, 1'b0, 1'b0, 0);
    doSnap();
    applyStimulus("rd06_after", 0, 6, 1'b0, '0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 0);

    // Out-of-range port with clear, response held for 4 cycles.
    applyStimulus("rd_oor", 3, 1, 1'b1, '0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4);

    // Last counter of the last port, and all bits of a port at once.
    pulse(2, 7, 3);
    stat_event = 24'h00FF00;
    tick();
    stat_event = '0;
    doSnap();
    applyStimulus("rd27", 2, 7, 1'b0, '0, 8'd3, 8'd3, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus("rd10", 1, 0, 1'b0, '0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus("rd17", 1, 7, 1'b0, '0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 0);

`ifdef ETH_MAC_STATS_SNAPSHOT_EN
    // Reads see the shadow, not the live value.
    pulse(2, 0, 10);
    doSnap();
    pulse(2, 0, 3);
    applyStimulus("snap_10", 2, 0, 1'b0, '0, 8'd10, 8'd10, 1'b0, 1'b0, 1'b0, 0);
    doSnap();
    applyStimulus("snap_13", 2, 0, 1'b0, '0, 8'd13, 8'd13, 1'b0, 1'b0, 1'b0, 0);
`endif

    // Reset while a response is pending drops it and zeroes everything.
    rd_req_valid = 1'b1; rd_req_port = 2'd0; rd_req_index = 3'd4;
    tick();
    rd_req_valid = 1'b0;
    check("rstresp/pending", 64'(s_resp_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstresp/valid", 64'(s_resp_valid), 64'd0);
    check("rstresp/ready", 64'(s_req_ready),  64'd1);
    check("rstresp/data",  64'(s_resp_data),  64'd0);
    doSnap();
    applyStimulus("post_rst04", 0, 4, 1'b0, '0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus("post_rst27", 2, 7, 1'b0, '0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
